branch_unit_x: RTL and testbench
================================

# branch_unit_x

Execute-stage branch resolution unit with a parametrised bimodal predictor, and the successor to the combinational branch comparator. It evaluates all six RV32 conditional-branch conditions on generic-width operands. It owns a table of 2-bit saturating counters that the fetch stage reads for predictions, and it raises a registered redirect on misprediction. It also keeps branch and mispredict performance counters.

## Interface
Parameters:
- XLEN, 32, operand width of rs1/rs2
- PC_W, 32, program-counter width
- BHT_ENTRIES, 64, predictor entries; power of two, ≥2
- CTR_INIT, 2'b01, counter reset value (weakly not-taken)
- CNT_W, 32, performance-counter width

Ports:
- clk  in  1  sole clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- f_pc  in  PC_W  fetch PC to predict
- f_pred_taken  out  1  combinational: MSB of counter at index f_pc[log2(BHT_ENTRIES)+1:2]
- x_valid  in  1  instruction in X is valid
- x_is_branch  in  1  instruction in X is a conditional branch
- x_funct3  in  3  branch condition
- x_rs1, x_rs2  in  XLEN  forwarded operands
- x_pc  in  PC_W  PC of the branch in X
- x_target  in  PC_W  computed branch target
- x_pred_taken  in  1  prediction carried down from fetch
- x_taken  out  1  combinational resolved outcome
- redirect_valid  out  1  registered one-cycle mispredict pulse
- redirect_pc  out  PC_W  registered correct next PC
- illegal_br  out  1  registered one-cycle pulse for funct3 010/011
- cnt_clr  in  1  synchronous clear of the performance counters
- br_count, mispred_count  out  CNT_W  performance counters

## Operation
- A resolve event occurs when x_valid & x_is_branch & ~redirect_valid. Any instruction in X during the redirect cycle is wrong-path and is ignored.
- Conditions by funct3:
  - 000: eq
  - 001: ne
  - 100: signed lt
  - 101: signed ge
  - 110: unsigned lt
  - 111: unsigned ge
  - 010/011: x_taken=0, no table update, no redirect; illegal_br pulses next cycle and br_count does not increment.
- x_taken is 0 whenever there is no resolve event. The logic is fully combinational with a default arm, so there are no latches.
- Mispredict = resolve & legal & (x_taken != x_pred_taken).
  - Next cycle: redirect_valid=1.
  - redirect_pc = x_taken ? x_target : x_pc+4, with PC_W wrap-around.
- Table update on each legal resolve, at index x_pc[log2(BHT_ENTRIES)+1:2]:
  - taken: saturating increment, 11 stays 11.
  - not taken: saturating decrement, 00 stays 00.
- Same-index read and write in one cycle: f_pred_taken returns the old value; there is no bypass.
- Counter states are 00 SNT, 01 WNT, 10 WT, 11 ST. Prediction = MSB.
- Performance counters:
  - br_count increments on each legal resolve; mispred_count increments on each mispredict.
  - Both wrap modulo 2^CNT_W.
  - When cnt_clr and an increment coincide, cnt_clr wins and the counter reads 0 next cycle.

## Timing
- Reset (async assert, sync release by the top level):
  - all table entries = CTR_INIT
  - redirect_valid=0, redirect_pc=0, illegal_br=0
  - br_count=0, mispred_count=0
- x_taken and f_pred_taken: 0-cycle combinational.
- redirect_valid, redirect_pc, illegal_br: 1-cycle latency, high for exactly one cycle per event.
- Table and counter updates are visible on outputs the cycle after the resolve.
- Back-to-back mispredicts are impossible: the second branch is suppressed by the redirect cycle.
- Reset asserted mid-operation clears a pending redirect immediately; no redirect is issued after release.

## Structure
- Shared package holds:
  - branch funct3 localparams (BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU)
  - 2-bit counter typedef and state constants
  - the index-extraction function
- One sub-module, branch_cond, performs the combinational XLEN-parametrised compare (funct3, rs1, rs2 → taken, illegal).
- Top level holds the counter table, redirect registers and performance counters.

## Test plan
- Reset, then read f_pc=0x100 → f_pred_taken=0. Resolve BEQ at 0x100 with rs1=rs2=5 and x_pred_taken=0 → x_taken=1. Next cycle: redirect_valid=1, redirect_pc=x_target, br_count=1, mispred_count=1.
- Signedness: rs1=0xFFFFFFFF, rs2=1 → BLT taken, BLTU not taken, BGE not taken, BGEU taken.
- Saturation: resolve the same PC taken 4 times (01→10→11→11), then not-taken once → counter 10, f_pred_taken still 1.
- Wrong-path suppression: a branch valid in X during the redirect cycle → no table update, no count, no second redirect.
- funct3=010 with x_valid=1 → x_taken=0, illegal_br pulses once, counters and table unchanged.
- Boundaries:
  - cnt_clr coincident with a mispredict → both counters 0.
  - x_pc=0xFFFFFFFC not-taken mispredict → redirect_pc=0x00000000.
  - rst_n dropped mid-redirect → redirect_valid=0 immediately.

Source files
------------

// File: rtl/branch_unit_x_pkg.sv
// Shared definitions for the branch unit: funct3 codes, 2-bit predictor
// counter type and states, predictor index extraction and counter update.
package branch_unit_x_pkg;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_SNT = 2'b00;
    localparam ctr_t CTR_WNT = 2'b01;
    localparam ctr_t CTR_WT  = 2'b10;
    localparam ctr_t CTR_ST  = 2'b11;

    // Word-aligned PC bits [idx_w+1:2] select the predictor entry.
    function automatic int unsigned bht_index(input logic [63:0] pc, input int unsigned idx_w);
        logic [63:0] mask;
        mask = (64'd1 << idx_w) - 64'd1;
        return 32'((pc >> 2) & mask);
    endfunction

    // Saturating 2-bit counter step toward the resolved direction.
    function automatic ctr_t ctr_update(input ctr_t cur, input logic taken);
        ctr_t nxt;
        nxt = cur;
        if (taken && cur != CTR_ST) begin
            nxt = cur + 2'd1;
        end else if (!taken && cur != CTR_SNT) begin
            nxt = cur - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_unit_x_cond.sv
// Combinational RV32 conditional-branch compare on XLEN-bit operands.
// Ports: funct3, rs1, rs2 in; taken_c (condition holds), illegal_c
// (funct3 is not a branch encoding) out.
module branch_cond
    import branch_unit_x_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            taken_c,
    output logic            illegal_c
);

    logic eq;
    logic lt_s;
    logic lt_u;

    assign eq   = (rs1 == rs2);
    assign lt_s = ($signed(rs1) < $signed(rs2));
    assign lt_u = (rs1 < rs2);

    // Condition select; 010/011 and anything else report illegal, never taken.
    always_comb begin
        taken_c   = 1'b0;
        illegal_c = 1'b0;
        case (funct3)
            BR_EQ:   taken_c = eq;
            BR_NE:   taken_c = ~eq;
            BR_LT:   taken_c = lt_s;
            BR_GE:   taken_c = ~lt_s;
            BR_LTU:  taken_c = lt_u;
            BR_GEU:  taken_c = ~lt_u;
            default: illegal_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_unit_x.sv
// Execute-stage branch resolution with a bimodal predictor table.
// Ports: f_pc -> f_pred_taken (comb prediction for fetch); x_* branch in X
// -> x_taken (comb outcome); redirect_valid/redirect_pc/illegal_br registered
// one-cycle pulses; cnt_clr clears br_count/mispred_count perf counters.
module branch_unit_x
    import branch_unit_x_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned PC_W        = 32,
    parameter int unsigned BHT_ENTRIES = 64,
    parameter logic [1:0]  CTR_INIT    = 2'b01,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PC_W-1:0]  f_pc,
    output logic             f_pred_taken,
    input  logic             x_valid,
    input  logic             x_is_branch,
    input  logic [2:0]       x_funct3,
    input  logic [XLEN-1:0]  x_rs1,
    input  logic [XLEN-1:0]  x_rs2,
    input  logic [PC_W-1:0]  x_pc,
    input  logic [PC_W-1:0]  x_target,
    input  logic             x_pred_taken,
    output logic             x_taken,
    output logic             redirect_valid,
    output logic [PC_W-1:0]  redirect_pc,
    output logic             illegal_br,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispred_count
);

    localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

    ctr_t bht [BHT_ENTRIES];

    logic [IDX_W-1:0] f_idx;
    logic [IDX_W-1:0] x_idx;
    logic             cond_taken_c;
    logic             cond_illegal_c;
    logic             resolve_c;
    logic             legal_resolve_c;
    logic             mispredict_c;

    assign f_idx = IDX_W'(bht_index(64'(f_pc), IDX_W));
    assign x_idx = IDX_W'(bht_index(64'(x_pc), IDX_W));

    // No bypass: a same-cycle update at f_idx is seen next cycle.
    assign f_pred_taken = bht[f_idx][1];

    branch_cond #(
        .XLEN (XLEN)
    ) u_cond (
        .funct3    (x_funct3),
        .rs1       (x_rs1),
        .rs2       (x_rs2),
        .taken_c   (cond_taken_c),
        .illegal_c (cond_illegal_c)
    );

    // The instruction in X during a redirect cycle is wrong-path.
    assign resolve_c       = x_valid & x_is_branch & ~redirect_valid;
    assign legal_resolve_c = resolve_c & ~cond_illegal_c;
    assign x_taken         = legal_resolve_c & cond_taken_c;
    assign mispredict_c    = legal_resolve_c & (x_taken != x_pred_taken);

    // Predictor table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= CTR_INIT;
            end
        end else if (legal_resolve_c) begin
            bht[x_idx] <= ctr_update(bht[x_idx], x_taken);
        end
    end

    // Redirect and illegal-branch pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            illegal_br     <= 1'b0;
        end else begin
            redirect_valid <= mispredict_c;
            illegal_br     <= resolve_c & cond_illegal_c;
            if (mispredict_c) begin
                redirect_pc <= x_taken ? x_target : x_pc + PC_W'(4);
            end
        end
    end

    // Performance counters; clear takes priority over a coincident increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count      <= '0;
            mispred_count <= '0;
        end else if (cnt_clr) begin
            br_count      <= '0;
            mispred_count <= '0;
        end else begin
            if (legal_resolve_c) begin
                br_count <= br_count + CNT_W'(1);
            end
            if (mispredict_c) begin
                mispred_count <= mispred_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_unit_x.sv
// Bench for branch_unit_x: behavioural model checked every cycle plus
// directed literal expectations.
module tb_branch_unit_x;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] f_pc;
    logic        f_pred_taken;
    logic        x_valid;
    logic        x_is_branch;
    logic [2:0]  x_funct3;
    logic [31:0] x_rs1;
    logic [31:0] x_rs2;
    logic [31:0] x_pc;
    logic [31:0] x_target;
    logic        x_pred_taken;
    logic        x_taken;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        illegal_br;
    logic        cnt_clr;
    logic [31:0] br_count;
    logic [31:0] mispred_count;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    branch_unit_x dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .f_pc           (f_pc),
        .f_pred_taken   (f_pred_taken),
        .x_valid        (x_valid),
        .x_is_branch    (x_is_branch),
        .x_funct3       (x_funct3),
        .x_rs1          (x_rs1),
        .x_rs2          (x_rs2),
        .x_pc           (x_pc),
        .x_target       (x_target),
        .x_pred_taken   (x_pred_taken),
        .x_taken        (x_taken),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .illegal_br     (illegal_br),
        .cnt_clr        (cnt_clr),
        .br_count       (br_count),
        .mispred_count  (mispred_count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    int          m_bht [64];
    logic [31:0] m_br;
    logic [31:0] m_mis;
    logic        m_rv;
    logic [31:0] m_rpc;
    logic        m_ill;

    function automatic int pidx(input logic [31:0] pc);
        return int'((pc / 4) % 64);
    endfunction

    function automatic logic br_eval(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b, output logic legal);
        legal = 1'b1;
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) < $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a < b;
            3'd7: return a >= b;
            default: begin legal = 1'b0; return 1'b0; end
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) m_bht[i] = 1;
            m_br = 0; m_mis = 0; m_rv = 0; m_rpc = 0; m_ill = 0;
        end else begin
            logic res, lg, t;
            res = x_valid && x_is_branch && !m_rv;
            t = br_eval(x_funct3, x_rs1, x_rs2, lg);
            m_ill = res && !lg;
            if (res && lg) begin
                m_br = m_br + 1;
                if (t) m_bht[pidx(x_pc)] = (m_bht[pidx(x_pc)] < 3) ? m_bht[pidx(x_pc)] + 1 : 3;
                else   m_bht[pidx(x_pc)] = (m_bht[pidx(x_pc)] > 0) ? m_bht[pidx(x_pc)] - 1 : 0;
                m_rv = (t != x_pred_taken);
                if (m_rv) begin
                    m_mis = m_mis + 1;
                    m_rpc = t ? x_target : x_pc + 32'd4;
                end
            end else begin
                m_rv = 1'b0;
            end
            if (cnt_clr) begin
                m_br = 0;
                m_mis = 0;
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        logic lg, t;
        t = br_eval(x_funct3, x_rs1, x_rs2, lg);
        chk("m_x_taken", x_taken, x_valid && x_is_branch && !m_rv && lg && t);
        chk("m_f_pred", f_pred_taken, m_bht[pidx(f_pc)] >= 2);
        chk("m_redirect_valid", redirect_valid, m_rv);
        if (m_rv) chk("m_redirect_pc", redirect_pc, m_rpc);
        chk("m_illegal_br", illegal_br, m_ill);
        chk("m_br_count", br_count, m_br);
        chk("m_mispred_count", mispred_count, m_mis);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        x_valid = 1'b0;
        x_is_branch = 1'b0;
    endtask

    task automatic br(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] pc, input logic [31:0] tgt, input logic pred);
        x_valid = 1'b1; x_is_branch = 1'b1; x_funct3 = f3;
        x_rs1 = a; x_rs2 = b; x_pc = pc; x_target = tgt; x_pred_taken = pred;
    endtask

    logic [2:0]  sg_f3  [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
    logic        sg_exp [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        rst_n = 1'b0; cnt_clr = 1'b0; f_pc = '0;
        idle();
        x_funct3 = '0; x_rs1 = '0; x_rs2 = '0; x_pc = '0; x_target = '0; x_pred_taken = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        f_pc = 32'h100;
        @(negedge clk);
        chk("rst_f_pred", f_pred_taken, 0);
        chk("rst_redirect_valid", redirect_valid, 0);
        chk("rst_redirect_pc", redirect_pc, 0);
        chk("rst_illegal_br", illegal_br, 0);
        chk("rst_br_count", br_count, 0);
        chk("rst_mispred_count", mispred_count, 0);
        tick();

        // BEQ taken, predicted not-taken
        br(3'd0, 32'd5, 32'd5, 32'h100, 32'h200, 1'b0);
        @(negedge clk); chk("beq_x_taken", x_taken, 1);
        tick(); idle();
        @(negedge clk);
        chk("beq_redirect_valid", redirect_valid, 1);
        chk("beq_redirect_pc", redirect_pc, 32'h200);
        chk("beq_br_count", br_count, 1);
        chk("beq_mispred_count", mispred_count, 1);
        chk("beq_f_pred", f_pred_taken, 1);
        tick();

        // Signedness: BLT, BLTU, BGE, BGEU on -1 vs 1
        for (int i = 0; i < 4; i++) begin
            br(sg_f3[i], 32'hFFFF_FFFF, 32'd1, 32'h10 + 32'(i * 4), 32'h400, sg_exp[i]);
            @(negedge clk); chk("sign_x_taken", x_taken, 64'(sg_exp[i]));
            tick();
        end
        idle(); tick();

        // Saturation at PC 0x104
        f_pc = 32'h104;
        repeat (4) begin
            br(3'd0, 32'd7, 32'd7, 32'h104, 32'h500, 1'b1);
            tick();
        end
        idle();
        @(negedge clk); chk("sat_f_pred_st", f_pred_taken, 1);
        tick();
        br(3'd1, 32'd7, 32'd7, 32'h104, 32'h500, 1'b1);
        @(negedge clk); chk("sat_nt_x_taken", x_taken, 0);
        tick(); idle();
        @(negedge clk);
        chk("sat_redirect_valid", redirect_valid, 1);
        chk("sat_redirect_pc", redirect_pc, 32'h108);
        chk("sat_f_pred_wt", f_pred_taken, 1);
        tick();

        // Wrong-path suppression
        br(3'd0, 32'd1, 32'd1, 32'h20, 32'h600, 1'b0);
        tick();
        br(3'd0, 32'd2, 32'd2, 32'h108, 32'h700, 1'b0);
        f_pc = 32'h108;
        @(negedge clk);
        chk("wp_redirect_valid", redirect_valid, 1);
        chk("wp_x_taken", x_taken, 0);
        tick(); idle();
        @(negedge clk);
        chk("wp_no_second_redirect", redirect_valid, 0);
        chk("wp_table_unchanged", f_pred_taken, 0);
        tick();

        // Illegal funct3
        br(3'b010, 32'd3, 32'd3, 32'h24, 32'h700, 1'b0);
        @(negedge clk); chk("ill_x_taken", x_taken, 0);
        tick(); idle();
        @(negedge clk);
        chk("ill_pulse", illegal_br, 1);
        chk("ill_no_redirect", redirect_valid, 0);
        tick();
        @(negedge clk); chk("ill_pulse_end", illegal_br, 0);
        tick();

        // cnt_clr coincident with a mispredict
        br(3'd0, 32'd3, 32'd3, 32'h28, 32'h800, 1'b0);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0; idle();
        @(negedge clk);
        chk("clr_br_count", br_count, 0);
        chk("clr_mispred_count", mispred_count, 0);
        chk("clr_redirect_valid", redirect_valid, 1);
        tick();

        // PC wrap on not-taken mispredict
        br(3'd1, 32'd9, 32'd9, 32'hFFFF_FFFC, 32'h900, 1'b1);
        tick(); idle();
        @(negedge clk);
        chk("wrap_redirect_valid", redirect_valid, 1);
        chk("wrap_redirect_pc", redirect_pc, 32'h0);
        tick();

        // Directed-random mix, model-checked
        for (int i = 0; i < 40; i++) begin
            x_valid      = ($urandom_range(0, 3) != 0);
            x_is_branch  = ($urandom_range(0, 4) != 0);
            x_funct3     = 3'($urandom_range(0, 7));
            x_rs1        = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 3)) : $urandom;
            x_rs2        = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 3)) : $urandom;
            x_pc         = {24'h0, 6'($urandom), 2'b00};
            x_target     = $urandom;
            x_pred_taken = 1'($urandom);
            f_pc         = {24'h0, 6'($urandom), 2'b00};
            cnt_clr      = ($urandom_range(0, 9) == 0);
            tick();
        end
        cnt_clr = 1'b0; idle(); tick();

        // Reset dropped during a redirect
        f_pc = 32'h104;
        br(3'd0, 32'd4, 32'd4, 32'h2C, 32'hA00, 1'b0);
        tick(); idle();
        #1 chk("rstmid_redirect_before", redirect_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_redirect_cleared", redirect_valid, 0);
        chk("rstmid_br_count", br_count, 0);
        chk("rstmid_table_reset", f_pred_taken, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk); chk("rstmid_no_redirect_1", redirect_valid, 0);
        tick();
        @(negedge clk); chk("rstmid_no_redirect_2", redirect_valid, 0);
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
